// File: rtl/robo_pkg.sv
// Shared types for the wall-following robot environment: orientations, FSM states and
// neighbour offsets used for sensor lookup and forward moves.
package robo_pkg;

  typedef enum logic [1:0] {
    OriN = 2'b00,
    OriS = 2'b01,
    OriL = 2'b10,
    OriO = 2'b11
  } orient_t;

  typedef enum logic [2:0] {
    StIdle,
    StSense,
    StCmd,
    StDone,
    StErro
  } state_t;

  // Two's-complement row/column deltas of the cell ahead (h*) and to the left (l*).
  typedef struct packed {
    logic [1:0] hl;
    logic [1:0] hc;
    logic [1:0] ll;
    logic [1:0] lc;
  } viz_t;

  function automatic viz_t vizinhos(orient_t o);
    viz_t v;
    unique case (o)
      OriN: v = {2'b11, 2'b00, 2'b00, 2'b11};
      OriS: v = {2'b01, 2'b00, 2'b00, 2'b01};
      OriL: v = {2'b00, 2'b01, 2'b11, 2'b00};
      OriO: v = {2'b00, 2'b11, 2'b01, 2'b00};
    endcase
    return v;
  endfunction

  function automatic logic [4:0] desloca(logic [4:0] a, logic [1:0] d);
    return a + {{3{d[1]}}, d};
  endfunction

  function automatic orient_t gira_esq(orient_t o);
    orient_t r;
    unique case (o)
      OriN: r = OriO;
      OriO: r = OriS;
      OriS: r = OriL;
      OriL: r = OriN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/robo_sensores.sv
// Combinational head/left lookup: pads the wall map with a border of walls so any neighbour
// outside the map reads as 1; also exports the cell ahead as the forward-move target.
module robo_sensores
  import robo_pkg::*;
#(
  parameter int unsigned N_LIN = 20,
  parameter int unsigned N_COL = 20
) (
  input  logic [N_COL:1] mapa [1:N_LIN],
  input  logic [4:0]     linha,
  input  logic [4:0]     coluna,
  input  orient_t        orient,
  output logic           head,
  output logic           left,
  output logic [4:0]     alvo_linha,
  output logic [4:0]     alvo_coluna
);

  viz_t       v;
  logic [4:0] esq_linha;
  logic [4:0] esq_coluna;
  logic [N_COL+1:0] pad [0:N_LIN+1];

  assign v           = vizinhos(orient);
  assign alvo_linha  = desloca(linha, v.hl);
  assign alvo_coluna = desloca(coluna, v.hc);
  assign esq_linha   = desloca(linha, v.ll);
  assign esq_coluna  = desloca(coluna, v.lc);

  always_comb begin
    for (int i = 0; i <= int'(N_LIN) + 1; i++) pad[i] = '1;
    for (int i = 1; i <= int'(N_LIN); i++) pad[i] = {1'b1, mapa[i], 1'b1};
  end

  assign head = pad[alvo_linha][alvo_coluna];
  assign left = pad[esq_linha][esq_coluna];

endmodule

// File: rtl/robo_ambiente.sv
// Hardware environment for the wall-following robot: wall map, robot pose and move budget.
// Optional visited-cell counter enabled by defining ROBO_AMB_VISITADAS_EN.
module robo_ambiente
  import robo_pkg::*;
#(
  parameter int unsigned N_LIN = 20,
  parameter int unsigned N_COL = 20,
  parameter int unsigned W_MOV = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             map_we,
  input  logic [4:0]       map_addr,
  input  logic [N_COL:1]   map_wdata,
  input  logic             start,
  input  logic [4:0]       start_linha,
  input  logic [4:0]       start_coluna,
  input  logic [1:0]       start_orient,
  input  logic [W_MOV-1:0] start_mov,
  input  logic             avancar,
  input  logic             girar,
  output logic             head,
  output logic             left,
  output logic             sens_valid,
  output logic [4:0]       linha,
  output logic [4:0]       coluna,
  output logic [1:0]       orient,
  output logic [W_MOV-1:0] mov_rest,
`ifdef ROBO_AMB_VISITADAS_EN
  output logic [8:0]       visitadas,
`endif
  output logic             busy,
  output logic             done,
  output logic             erro
);

  localparam logic [4:0] LinMax = 5'(N_LIN);
  localparam logic [4:0] ColMax = 5'(N_COL);

  state_t           state_q, state_d;
  logic [4:0]       linha_q, linha_d, coluna_q, coluna_d;
  orient_t          orient_q, orient_d;
  logic [W_MOV-1:0] mov_q, mov_d;
  logic             head_q, head_d, left_q, left_d;
  logic [N_COL:1]   mapa_q [1:N_LIN];

  logic       sen_head, sen_left, start_ok;
  logic [4:0] alvo_linha, alvo_coluna;

  robo_sensores #(.N_LIN(N_LIN), .N_COL(N_COL)) u_sensores (
    .mapa       (mapa_q),
    .linha      (linha_q),
    .coluna     (coluna_q),
    .orient     (orient_q),
    .head       (sen_head),
    .left       (sen_left),
    .alvo_linha (alvo_linha),
    .alvo_coluna(alvo_coluna)
  );

  assign start_ok = (start_linha >= 5'd1) && (start_linha <= LinMax) &&
                    (start_coluna >= 5'd1) && (start_coluna <= ColMax) &&
                    !mapa_q[start_linha][start_coluna];

  // Map survives reset; writes are dropped when start is seen in the same cycle.
  always_ff @(posedge clock) begin
    if (state_q == StIdle && map_we && !start && map_addr >= 5'd1 && map_addr <= LinMax) begin
      mapa_q[map_addr] <= map_wdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    linha_d  = linha_q;
    coluna_d = coluna_q;
    orient_d = orient_q;
    mov_d    = mov_q;
    head_d   = head_q;
    left_d   = left_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          linha_d  = start_linha;
          coluna_d = start_coluna;
          orient_d = orient_t'(start_orient);
          mov_d    = start_mov;
          if (!start_ok)            state_d = StErro;
          else if (start_mov == '0) state_d = StDone;
          else                      state_d = StSense;
        end
      end
      StSense: begin
        head_d  = sen_head;
        left_d  = sen_left;
        state_d = StCmd;
      end
      StCmd: begin
        if (avancar && head_q) begin
          state_d = StErro;
        end else begin
          if (avancar) begin
            linha_d  = alvo_linha;
            coluna_d = alvo_coluna;
          end else if (girar) begin
            orient_d = gira_esq(orient_q);
          end
          mov_d   = mov_q - W_MOV'(1);
          state_d = (mov_q == W_MOV'(1)) ? StDone : StSense;
        end
      end
      StDone, StErro: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      linha_q  <= '0;
      coluna_q <= '0;
      orient_q <= OriN;
      mov_q    <= '0;
      head_q   <= 1'b0;
      left_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      linha_q  <= linha_d;
      coluna_q <= coluna_d;
      orient_q <= orient_d;
      mov_q    <= mov_d;
      head_q   <= head_d;
      left_q   <= left_d;
    end
  end

`ifdef ROBO_AMB_VISITADAS_EN
  logic [N_COL:1] vis_q [1:N_LIN];
  logic [8:0]     vis_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      vis_cnt_q <= '0;
    end else if (state_q == StIdle && start && start_ok) begin
      for (int i = 1; i <= int'(N_LIN); i++) vis_q[i] <= '0;
      vis_q[start_linha][start_coluna] <= 1'b1;
      vis_cnt_q <= 9'd1;
    end else if (state_q == StCmd && avancar && !head_q) begin
      vis_q[alvo_linha][alvo_coluna] <= 1'b1;
      if (!vis_q[alvo_linha][alvo_coluna] && vis_cnt_q != '1) vis_cnt_q <= vis_cnt_q + 9'd1;
    end
  end

  assign visitadas = vis_cnt_q;
`endif

  assign head       = head_q;
  assign left       = left_q;
  assign sens_valid = (state_q == StCmd);
  assign linha      = linha_q;
  assign coluna     = coluna_q;
  assign orient     = orient_q;
  assign mov_rest   = mov_q;
  assign busy       = (state_q == StSense) || (state_q == StCmd);
  assign done       = (state_q == StDone);
  assign erro       = (state_q == StErro);

endmodule
